// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/sequence controller for the accumulator execute unit.
// Fetches opcode/operand bytes, drives data-ROM rd/wr handshakes, runs sleep delays.
module acc_cpu_sequencer #(
    parameter int PC_W         = 8,
    parameter int SLEEP_CYCLES = 10000,
    parameter int TIMER_W      = 25
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] pm_addr,
    output logic            pm_rd,
    input  logic [7:0]      pm_data,
    output logic [7:0]      code,
    output logic [7:0]      in_data,
    output logic            exec_en,
    output logic            rd,
    output logic            wr,
    input  logic            mem_ack,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [3:0]      dbg_state
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_OPFETCH = 4'd3;
    localparam logic [3:0] S_OPLATCH = 4'd4;
    localparam logic [3:0] S_MEM     = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_SLEEP   = 4'd7;
    localparam logic [3:0] S_HALT    = 4'd8;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LOAD_ROM = 8'h01;
    localparam logic [7:0] OP_LOAD_NUM = 8'h02;
    localparam logic [7:0] OP_OUT_ROM  = 8'h03;
    localparam logic [7:0] OP_CLR      = 8'h04;
    localparam logic [7:0] OP_INC      = 8'h05;
    localparam logic [7:0] OP_SLEEP    = 8'h0A;
    localparam logic [7:0] OP_DEC      = 8'h0C;
    localparam logic [7:0] OP_OUT      = 8'h0D;
    localparam logic [7:0] OP_HALT     = 8'hFF;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SLEEP_CYCLES - 1);

    logic [3:0]         state_q,   state_d;
    logic [PC_W-1:0]    pc_q,      pc_d;
    logic [7:0]         opcode_q,  opcode_d;
    logic [7:0]         operand_q, operand_d;
    logic [TIMER_W-1:0] timer_q,   timer_d;
    logic               illegal_q, illegal_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        timer_d   = timer_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                // Operand cleared so no-operand ops present in_data=0 in EXEC.
                opcode_d  = pm_data;
                operand_d = '0;
                pc_d      = pc_q + PC_W'(1);
                case (pm_data)
                    OP_LOAD_ROM, OP_LOAD_NUM, OP_OUT_ROM: state_d = S_OPFETCH;
                    OP_SLEEP: begin
                        timer_d = '0;
                        state_d = S_SLEEP;
                    end
                    OP_HALT:                      state_d = S_HALT;
                    OP_NOP:                       state_d = S_FETCH;
                    OP_CLR, OP_INC, OP_DEC, OP_OUT: state_d = S_EXEC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_OPFETCH: state_d = S_OPLATCH;
            S_OPLATCH: begin
                operand_d = pm_data;
                pc_d      = pc_q + PC_W'(1);
                state_d   = (opcode_q == OP_LOAD_NUM) ? S_EXEC : S_MEM;
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = (opcode_q == OP_LOAD_ROM) ? S_EXEC : S_FETCH;
                end
            end
            S_EXEC: state_d = S_FETCH;
            S_SLEEP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = S_FETCH;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            timer_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            timer_q   <= timer_d;
            illegal_q <= illegal_d;
        end
    end

    // MEM is only entered for load_rom/out_rom, so rd and wr are mutually exclusive.
    assign pm_rd     = (state_q == S_FETCH) || (state_q == S_OPFETCH);
    assign pm_addr   = pc_q;
    assign exec_en   = (state_q == S_EXEC);
    assign code      = exec_en ? opcode_q : 8'h00;
    assign in_data   = ((state_q == S_MEM) || (state_q == S_EXEC)) ? operand_q : 8'h00;
    assign rd        = (state_q == S_MEM) && (opcode_q == OP_LOAD_ROM);
    assign wr        = (state_q == S_MEM) && (opcode_q == OP_OUT_ROM);
    assign pc        = pc_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Bench for acc_cpu_sequencer: instruction-level timing model compared every cycle,
// plus literal cycle/value expectations for the directed programs.
module tb_acc_cpu_sequencer;

    localparam int PC_W         = 8;
    localparam int SLEEP_CYCLES = 4;
    localparam int TIMER_W      = 3;

    logic       clk = 1'b0;
    logic       reset, start, mem_ack;
    logic [7:0] pm_addr, pm_data, code, in_data, pc;
    logic       pm_rd, exec_en, rd, wr, busy, halted, illegal;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    acc_cpu_sequencer #(
        .PC_W(PC_W), .SLEEP_CYCLES(SLEEP_CYCLES), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data),
        .code(code), .in_data(in_data), .exec_en(exec_en),
        .rd(rd), .wr(wr), .mem_ack(mem_ack),
        .pc(pc), .busy(busy), .halted(halted), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    // Program memory: registered read, data valid the cycle after pm_rd.
    logic [7:0] pm [256];
    always @(posedge clk) if (pm_rd) pm_data <= pm[pm_addr];

    int cnt = 0;
    int c0  = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Expected outputs for the current cycle, set by the model.
    bit         chk_en = 1'b0;
    logic       exp_pm_rd, exp_exec_en, exp_rd, exp_wr, exp_busy, exp_halted, exp_illegal;
    logic [7:0] exp_pm_addr, exp_code, exp_in_data, exp_pc;

    always @(negedge clk) begin
        if (chk_en) begin
            check("pm_rd",   32'(pm_rd),   32'(exp_pm_rd));
            if (exp_pm_rd) check("pm_addr", 32'(pm_addr), 32'(exp_pm_addr));
            check("exec_en", 32'(exec_en), 32'(exp_exec_en));
            check("code",    32'(code),    32'(exp_code));
            check("in_data", 32'(in_data), 32'(exp_in_data));
            check("rd",      32'(rd),      32'(exp_rd));
            check("wr",      32'(wr),      32'(exp_wr));
            check("pc",      32'(pc),      32'(exp_pc));
            check("busy",    32'(busy),    32'(exp_busy));
            check("halted",  32'(halted),  32'(exp_halted));
            check("illegal", 32'(illegal), 32'(exp_illegal));
        end
    end

    // Event logs for literal expectations; rel cycle 1 = first FETCH after start accept.
    int         ex_rel[$];
    logic [7:0] ex_code[$];
    logic [7:0] ex_in[$];
    int         f_rel[$];
    logic [7:0] f_addr[$];
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         last_rd_rel = 0;
    logic [7:0] rdwr_in = 8'h00;

    always @(negedge clk) begin
        if (exec_en) begin
            ex_rel.push_back(cnt - c0 + 1);
            ex_code.push_back(code);
            ex_in.push_back(in_data);
        end
        if (pm_rd) begin
            f_rel.push_back(cnt - c0 + 1);
            f_addr.push_back(pm_addr);
        end
        if (rd) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_rel <= cnt - c0 + 1;
            rdwr_in     <= in_data;
        end
        if (wr) begin
            wr_cnt  <= wr_cnt + 1;
            rdwr_in <= in_data;
        end
    end

    // Behavioural model state.
    logic [7:0] m_pc;
    bit         m_ill, m_halt;

    function automatic bit is_legal(input logic [7:0] op);
        return op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0A, 8'h0C, 8'h0D, 8'hFF};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input bit prd, input bit xen, input logic [7:0] xcode,
                              input logic [7:0] xin, input bit xrd, input bit xwr, input bit xbusy);
        exp_pm_rd   = prd;
        exp_pm_addr = m_pc;
        exp_exec_en = xen;
        exp_code    = xcode;
        exp_in_data = xin;
        exp_rd      = xrd;
        exp_wr      = xwr;
        exp_busy    = xbusy;
        exp_halted  = m_halt;
        exp_illegal = m_ill;
        exp_pc      = m_pc;
    endtask

    // start is ignored while busy, so it is toggled randomly there.
    task automatic noise_start();
        start = ($urandom_range(0, 3) == 0);
    endtask

    // Pulse start from IDLE/HALT and walk the program instruction by instruction.
    // ack_n > 0 fixes the MEM wait length, 0 picks it at random.
    task automatic run_prog(input int max_instr, input int ack_n);
        logic [7:0] op, opnd;
        int n;
        start = 1'b1;
        expect_cyc(0, 0, 8'h00, 8'h00, 0, 0, 0);
        chk_en = 1'b1;
        step();
        start  = 1'b0;
        c0     = cnt;
        m_pc   = 8'h00;
        m_halt = 1'b0;
        for (int i = 0; i < max_instr; i++) begin
            noise_start(); expect_cyc(1, 0, 8'h00, 8'h00, 0, 0, 1); step();
            op = pm[m_pc];
            noise_start(); expect_cyc(0, 0, 8'h00, 8'h00, 0, 0, 1); step();
            m_pc = m_pc + 8'h01;
            if (!is_legal(op)) m_ill = 1'b1;
            if (op == 8'hFF) begin
                m_halt = 1'b1;
                start  = 1'b0;
                expect_cyc(0, 0, 8'h00, 8'h00, 0, 0, 0);
                step();
                return;
            end
            if (op == 8'h01 || op == 8'h02 || op == 8'h03) begin
                noise_start(); expect_cyc(1, 0, 8'h00, 8'h00, 0, 0, 1); step();
                opnd = pm[m_pc];
                noise_start(); expect_cyc(0, 0, 8'h00, 8'h00, 0, 0, 1); step();
                m_pc = m_pc + 8'h01;
                if (op == 8'h02) begin
                    noise_start(); expect_cyc(0, 1, op, opnd, 0, 0, 1); step();
                end else begin
                    n = (ack_n > 0) ? ack_n : int'($urandom_range(1, 4));
                    for (int k = 1; k <= n; k++) begin
                        noise_start();
                        mem_ack = (k == n);
                        expect_cyc(0, 0, 8'h00, opnd, op == 8'h01, op == 8'h03, 1);
                        step();
                    end
                    mem_ack = 1'b0;
                    if (op == 8'h01) begin
                        noise_start(); expect_cyc(0, 1, op, opnd, 0, 0, 1); step();
                    end
                end
            end else if (op == 8'h0A) begin
                repeat (SLEEP_CYCLES) begin
                    noise_start(); expect_cyc(0, 0, 8'h00, 8'h00, 0, 0, 1); step();
                end
            end else if (is_legal(op) && op != 8'h00) begin
                noise_start(); expect_cyc(0, 1, op, 8'h00, 0, 0, 1); step();
            end
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        chk_en  = 1'b0;
        reset   = 1'b1;
        start   = 1'b0;
        mem_ack = 1'b0;
        step();
        m_pc   = 8'h00;
        m_ill  = 1'b0;
        m_halt = 1'b0;
        expect_cyc(0, 0, 8'h00, 8'h00, 0, 0, 0);
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4);
        for (int i = 0; i < 256; i++) pm[i] = 8'hFF;
        pm[0] = b0; pm[1] = b1; pm[2] = b2; pm[3] = b3; pm[4] = b4;
    endtask

    initial begin
        int b_ex, b_rd, b_wr, b_f, w, found, wrapped, r;
        logic [7:0] ops [11];
        ops[0] = 8'h00; ops[1] = 8'h01; ops[2] = 8'h02; ops[3] = 8'h03; ops[4] = 8'h04;
        ops[5] = 8'h05; ops[6] = 8'h0A; ops[7] = 8'h0C; ops[8] = 8'h0D; ops[9] = 8'hFF;
        ops[10] = 8'h00;
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0; pm_data = 8'h00;

        // load_num / inc / out / halt, then restart from HALT.
        load_prog(8'h02, 8'h2A, 8'h05, 8'h0D, 8'hFF);
        do_reset();
        b_ex = ex_rel.size();
        run_prog(20, 0);
        check("t1_exec_count", 32'(ex_rel.size() - b_ex), 32'd3);
        if (ex_rel.size() - b_ex >= 3) begin
            check("t1_ldnum_cycle", 32'(ex_rel[b_ex]), 32'd5);
            check("t1_ldnum_code",  32'(ex_code[b_ex]), 32'h02);
            check("t1_ldnum_data",  32'(ex_in[b_ex]), 32'h2A);
            check("t1_inc_cycle",   32'(ex_rel[b_ex+1]), 32'd8);
            check("t1_inc_code",    32'(ex_code[b_ex+1]), 32'h05);
            check("t1_out_cycle",   32'(ex_rel[b_ex+2]), 32'd11);
            check("t1_out_code",    32'(ex_code[b_ex+2]), 32'h0D);
        end
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_pc",     32'(pc), 32'd5);
        repeat (3) step();
        b_ex = ex_rel.size();
        run_prog(20, 0);
        check("t1_restart_cycle", 32'(ex_rel.size() > b_ex ? ex_rel[b_ex] : 0), 32'd5);
        check("t1_restart_pc", 32'(pc), 32'd5);

        // load_rom with a 3-cycle ack delay.
        load_prog(8'h01, 8'h10, 8'hFF, 8'hFF, 8'hFF);
        do_reset();
        b_ex = ex_rel.size(); b_rd = rd_cnt; b_wr = wr_cnt;
        run_prog(20, 3);
        check("t2_rd_cycles", 32'(rd_cnt - b_rd), 32'd3);
        check("t2_wr_cycles", 32'(wr_cnt - b_wr), 32'd0);
        check("t2_rd_addr", 32'(rdwr_in), 32'h10);
        check("t2_last_rd", 32'(last_rd_rel), 32'd7);
        check("t2_exec_cycle", 32'(ex_rel.size() > b_ex ? ex_rel[b_ex] : 0), 32'd8);
        check("t2_exec_code", 32'(ex_code.size() > b_ex ? ex_code[b_ex] : 8'h00), 32'h01);
        check("t2_exec_data", 32'(ex_in.size() > b_ex ? ex_in[b_ex] : 8'h00), 32'h10);

        // out_rom with immediate ack: no exec, next fetch at pc=2.
        load_prog(8'h03, 8'h20, 8'hFF, 8'hFF, 8'hFF);
        do_reset();
        b_ex = ex_rel.size(); b_rd = rd_cnt; b_wr = wr_cnt; b_f = f_rel.size();
        run_prog(20, 1);
        check("t3_wr_cycles", 32'(wr_cnt - b_wr), 32'd1);
        check("t3_rd_cycles", 32'(rd_cnt - b_rd), 32'd0);
        check("t3_wr_addr", 32'(rdwr_in), 32'h20);
        check("t3_exec_count", 32'(ex_rel.size() - b_ex), 32'd0);
        found = -1;
        for (int i = b_f; i < f_rel.size(); i++) if (f_rel[i] == 6) found = int'(f_addr[i]);
        check("t3_next_fetch", 32'(found), 32'd2);

        // sleep then clr.
        load_prog(8'h0A, 8'h04, 8'hFF, 8'hFF, 8'hFF);
        do_reset();
        b_ex = ex_rel.size();
        run_prog(20, 0);
        check("t4_clr_cycle", 32'(ex_rel.size() > b_ex ? ex_rel[b_ex] : 0), 32'd9);
        check("t4_clr_code", 32'(ex_code.size() > b_ex ? ex_code[b_ex] : 8'h00), 32'h04);

        // Illegal opcode at 0xFF, PC wraps to 0 and clr runs again.
        for (int i = 0; i < 256; i++) pm[i] = 8'h00;
        pm[0] = 8'h04; pm[255] = 8'h77;
        do_reset();
        b_ex = ex_rel.size(); b_f = f_rel.size();
        run_prog(257, 0);
        check("t5_illegal", 32'(illegal), 32'd1);
        check("t5_exec_count", 32'(ex_rel.size() - b_ex), 32'd2);
        wrapped = 0;
        for (int i = b_f; i + 1 < f_addr.size(); i++)
            if (f_addr[i] == 8'hFF && f_addr[i+1] == 8'h00) wrapped = 1;
        check("t5_pc_wrap", 32'(wrapped), 32'd1);

        // Reset while rd is waiting for ack, then restart.
        load_prog(8'h01, 8'h10, 8'hFF, 8'hFF, 8'hFF);
        do_reset();
        chk_en = 1'b0;
        start = 1'b1; step(); start = 1'b0; mem_ack = 1'b0;
        w = 0;
        while (!rd && w < 20) begin step(); w++; end
        check("t6_rd_reached", 32'(rd), 32'd1);
        reset = 1'b1; step();
        check("t6_rd_dropped", 32'(rd), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pc", 32'(pc), 32'd0);
        check("t6_exec_en", 32'(exec_en), 32'd0);
        reset = 1'b0; step();
        m_pc = 8'h00; m_ill = 1'b0; m_halt = 1'b0;
        b_ex = ex_rel.size();
        run_prog(20, 2);
        check("t6_restart_exec", 32'(ex_rel.size() > b_ex ? ex_rel[b_ex] : 0), 32'd7);
        check("t6_restart_pc", 32'(pc), 32'd3);

        // Random programs with random ack delays.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) begin
                r = int'($urandom_range(0, 12));
                if (r <= 10) pm[i] = ops[r];
                else pm[i] = 8'($urandom_range(0, 255));
            end
            do_reset();
            run_prog(40, 0);
        end

        chk_en = 1'b0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
